// File: rtl/rnn_param_load_ctrl.sv
// Parameter load sequencer: streams ROWS*COLS matrix words then VLEN
// vector words from a valid/ready source into two parameter stores.
module rnn_param_load_ctrl #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 16,
    parameter int unsigned VLEN = 16,
    localparam int unsigned IW = $clog2(ROWS),
    localparam int unsigned JW = $clog2(COLS),
    localparam int unsigned VW = $clog2(VLEN)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [15:0]   in_data,
    output logic          in_ready,
    output logic          mat_write,
    output logic [IW-1:0] mat_seli,
    output logic [JW-1:0] mat_selj,
    output logic [15:0]   mat_param,
    output logic          vec_write,
    output logic [VW-1:0] vec_sel,
    output logic [15:0]   vec_param,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_MAT,
        S_LOAD_VEC,
        S_DONE
    } state_e;

    localparam logic [IW-1:0] IMAX = IW'(ROWS - 1);
    localparam logic [JW-1:0] JMAX = JW'(COLS - 1);
    localparam logic [VW-1:0] VMAX = VW'(VLEN - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] seli_q, seli_d;
    logic [JW-1:0] selj_q, selj_d;
    logic [VW-1:0] sel_q, sel_d;

    logic          mat_write_q, mat_write_d;
    logic [IW-1:0] mat_seli_q, mat_seli_d;
    logic [JW-1:0] mat_selj_q, mat_selj_d;
    logic [15:0]   mat_param_q, mat_param_d;
    logic          vec_write_q, vec_write_d;
    logic [VW-1:0] vec_sel_q, vec_sel_d;
    logic [15:0]   vec_param_q, vec_param_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          loading;
    logic          accept;

    // in_ready drops combinationally on abort so no word is lost that cycle
    assign loading  = (state_q == S_LOAD_MAT) || (state_q == S_LOAD_VEC);
    assign in_ready = loading && !abort;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        seli_d      = seli_q;
        selj_d      = selj_q;
        sel_d       = sel_q;
        mat_write_d = 1'b0;
        mat_seli_d  = mat_seli_q;
        mat_selj_d  = mat_selj_q;
        mat_param_d = mat_param_q;
        vec_write_d = 1'b0;
        vec_sel_d   = vec_sel_q;
        vec_param_d = vec_param_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_MAT;
                    seli_d  = '0;
                    selj_d  = '0;
                    sel_d   = '0;
                end
            end
            S_LOAD_MAT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    mat_write_d = 1'b1;
                    mat_seli_d  = seli_q;
                    mat_selj_d  = selj_q;
                    mat_param_d = in_data;
                    if (selj_q == JMAX) begin
                        selj_d = '0;
                        if (seli_q == IMAX) begin
                            state_d = S_LOAD_VEC;
                            sel_d   = '0;
                        end else begin
                            seli_d = seli_q + IW'(1);
                        end
                    end else begin
                        selj_d = selj_q + JW'(1);
                    end
                end
            end
            S_LOAD_VEC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    vec_write_d = 1'b1;
                    vec_sel_d   = sel_q;
                    vec_param_d = in_data;
                    if (sel_q == VMAX) begin
                        state_d = S_DONE;
                    end else begin
                        sel_d = sel_q + VW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            seli_q      <= '0;
            selj_q      <= '0;
            sel_q       <= '0;
            mat_write_q <= 1'b0;
            mat_seli_q  <= '0;
            mat_selj_q  <= '0;
            mat_param_q <= '0;
            vec_write_q <= 1'b0;
            vec_sel_q   <= '0;
            vec_param_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seli_q      <= seli_d;
            selj_q      <= selj_d;
            sel_q       <= sel_d;
            mat_write_q <= mat_write_d;
            mat_seli_q  <= mat_seli_d;
            mat_selj_q  <= mat_selj_d;
            mat_param_q <= mat_param_d;
            vec_write_q <= vec_write_d;
            vec_sel_q   <= vec_sel_d;
            vec_param_q <= vec_param_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mat_write = mat_write_q;
    assign mat_seli  = mat_seli_q;
    assign mat_selj  = mat_selj_q;
    assign mat_param = mat_param_q;
    assign vec_write = vec_write_q;
    assign vec_sel   = vec_sel_q;
    assign vec_param = vec_param_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rnn_param_load_ctrl.sv
// Bench for rnn_param_load_ctrl: word-count reference model, per-cycle
// checks of every output, and scenario tasks for bubbles/start/abort/reset.
module tb_rnn_param_load_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 16;
    localparam int VLEN = 16;
    localparam int IW = $clog2(ROWS);
    localparam int JW = $clog2(COLS);
    localparam int VW = $clog2(VLEN);
    localparam int RC = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data = '0;
    logic          in_ready;
    logic          mat_write;
    logic [IW-1:0] mat_seli;
    logic [JW-1:0] mat_selj;
    logic [15:0]   mat_param;
    logic          vec_write;
    logic [VW-1:0] vec_sel;
    logic [15:0]   vec_param;
    logic          busy;
    logic          done;

    rnn_param_load_ctrl #(.ROWS(ROWS), .COLS(COLS), .VLEN(VLEN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mat_write(mat_write), .mat_seli(mat_seli), .mat_selj(mat_selj),
        .mat_param(mat_param), .vec_write(vec_write), .vec_sel(vec_sel),
        .vec_param(vec_param), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: words accepted so far in the current load
    bit            m_load, m_done;
    int            m_k;
    logic          e_mw, e_vw, e_busy, e_done;
    logic [IW-1:0] e_mi;
    logic [JW-1:0] e_mj;
    logic [15:0]   e_mp, e_vp;
    logic [VW-1:0] e_vs;
    int            n_mw, n_vw, n_done, n_acc;

    task automatic model_reset();
        m_load = 0; m_done = 0; m_k = 0;
        e_mw = 0; e_vw = 0; e_busy = 0; e_done = 0;
        e_mi = '0; e_mj = '0; e_mp = '0; e_vs = '0; e_vp = '0;
    endtask

    task automatic clear_counts();
        n_mw = 0; n_vw = 0; n_done = 0; n_acc = 0;
    endtask

    // one clock cycle: drive, check at negedge, advance model at posedge
    task automatic step(input logic v, input logic [15:0] d,
                        input logic s, input logic a);
        logic e_rdy;
        bit was_load, was_done;
        in_valid = v; in_data = d; start = s; abort = a;
        @(negedge clk);
        e_rdy = m_load && !a;
        n_checks += 10;
        if (in_ready !== e_rdy) begin
            n_fail++;
            $display("FAIL in_ready got %b exp %b k=%0d", in_ready, e_rdy, m_k);
        end
        if (mat_write !== e_mw) begin
            n_fail++;
            $display("FAIL mat_write got %b exp %b k=%0d", mat_write, e_mw, m_k);
        end
        if (vec_write !== e_vw) begin
            n_fail++;
            $display("FAIL vec_write got %b exp %b k=%0d", vec_write, e_vw, m_k);
        end
        if (busy !== e_busy) begin
            n_fail++;
            $display("FAIL busy got %b exp %b k=%0d", busy, e_busy, m_k);
        end
        if (done !== e_done) begin
            n_fail++;
            $display("FAIL done got %b exp %b k=%0d", done, e_done, m_k);
        end
        if (mat_seli !== e_mi) begin
            n_fail++;
            $display("FAIL mat_seli got %0d exp %0d", mat_seli, e_mi);
        end
        if (mat_selj !== e_mj) begin
            n_fail++;
            $display("FAIL mat_selj got %0d exp %0d", mat_selj, e_mj);
        end
        if (mat_param !== e_mp) begin
            n_fail++;
            $display("FAIL mat_param got %h exp %h", mat_param, e_mp);
        end
        if (vec_sel !== e_vs) begin
            n_fail++;
            $display("FAIL vec_sel got %0d exp %0d", vec_sel, e_vs);
        end
        if (vec_param !== e_vp) begin
            n_fail++;
            $display("FAIL vec_param got %h exp %h", vec_param, e_vp);
        end
        if (mat_write === 1'b1) n_mw++;
        if (vec_write === 1'b1) n_vw++;
        if (done === 1'b1) n_done++;

        was_load = m_load;
        was_done = m_done;
        e_mw = 0;
        e_vw = 0;
        if (was_done) begin
            m_done = 0;
        end else if (!was_load) begin
            if (s) begin
                m_load = 1;
                m_k = 0;
            end
        end else if (a) begin
            m_load = 0;
        end else if (v) begin
            n_acc++;
            if (m_k < RC) begin
                e_mw = 1;
                e_mi = IW'(m_k / COLS);
                e_mj = JW'(m_k % COLS);
                e_mp = d;
            end else begin
                e_vw = 1;
                e_vs = VW'(m_k - RC);
                e_vp = d;
            end
            m_k++;
            if (m_k == RC + VLEN) begin
                m_load = 0;
                m_done = 1;
            end
        end
        e_busy = m_load || m_done;
        e_done = m_done;
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random; data sequential or random
    task automatic run_seq(input int vmode, input bit seq, input logic [15:0] first,
                           input int start_at, input int abort_at, input int stop_at);
        int cyc;
        bit tog;
        bit aborted;
        logic v, s, a;
        logic [15:0] d;
        cyc = 0;
        tog = 1;
        aborted = 0;
        step(1'b0, 16'h0, 1'b1, 1'b0);
        while ((m_load || m_done) && cyc < 2000) begin
            if (m_load && m_k == stop_at) return;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? logic'(tog) :
                logic'($urandom_range(3) != 0);
            tog = !tog;
            d = seq ? ((m_k == 0) ? first : 16'(m_k)) : 16'($urandom);
            s = (start_at >= 0) && ((m_load && m_k == start_at) || m_done);
            a = m_load && (m_k == abort_at) && !aborted;
            if (a) aborted = 1;
            step(v, d, s, a);
            cyc++;
        end
        n_checks++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL timeout got %0d cycles exp <2000", cyc);
        end
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 0; abort = 0; in_valid = 0; in_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, mat_write, mat_seli, mat_selj, mat_param, vec_write,
             vec_sel, vec_param, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got nonzero exp zero rdy=%b busy=%b",
                     in_ready, busy);
        end
        do_reset();
        clear_counts();
        repeat (3) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic test_full_load();
        clear_counts();
        run_seq(0, 1, 16'h0000, -1, -1, -1);
        n_checks += 3;
        if (n_mw !== RC) begin
            n_fail++;
            $display("FAIL full_mat_count got %0d exp %0d", n_mw, RC);
        end
        if (n_vw !== VLEN) begin
            n_fail++;
            $display("FAIL full_vec_count got %0d exp %0d", n_vw, VLEN);
        end
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL full_done_count got %0d exp 1", n_done);
        end
    endtask

    task automatic test_bubbles();
        clear_counts();
        run_seq(1, 1, 16'hDEAD, -1, -1, -1);
        n_checks += 2;
        if (n_mw + n_vw !== n_acc) begin
            n_fail++;
            $display("FAIL bubble_strobes got %0d exp %0d", n_mw + n_vw, n_acc);
        end
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL bubble_done got %0d exp 1", n_done);
        end
    endtask

    task automatic test_start_ignored();
        clear_counts();
        run_seq(2, 0, 16'h0, 20, -1, -1);
        n_checks += 2;
        if (n_mw !== RC || n_vw !== VLEN) begin
            n_fail++;
            $display("FAIL start_ign_counts got %0d/%0d exp %0d/%0d",
                     n_mw, n_vw, RC, VLEN);
        end
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL start_ign_done got %0d exp 1", n_done);
        end
    endtask

    task automatic test_abort();
        clear_counts();
        run_seq(2, 0, 16'h0, -1, 10, -1);
        n_checks += 2;
        if (n_mw !== 10) begin
            n_fail++;
            $display("FAIL abort_mat_count got %0d exp 10", n_mw);
        end
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_done got %0d exp 0", n_done);
        end
        clear_counts();
        run_seq(2, 0, 16'h0, -1, -1, -1);
        n_checks++;
        if (n_done !== 1 || n_mw !== RC) begin
            n_fail++;
            $display("FAIL abort_restart got done=%0d mat=%0d exp 1/%0d",
                     n_done, n_mw, RC);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        run_seq(0, 0, 16'h0, -1, -1, 70);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mat_write, mat_seli, mat_selj, mat_param, vec_write,
             vec_sel, vec_param, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got nonzero exp zero vw=%b busy=%b",
                     vec_write, busy);
        end
        do_reset();
        clear_counts();
        run_seq(2, 0, 16'h0, -1, -1, -1);
        n_checks++;
        if (n_done !== 1 || n_vw !== VLEN) begin
            n_fail++;
            $display("FAIL midreset_reload got done=%0d vec=%0d exp 1/%0d",
                     n_done, n_vw, VLEN);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        for (int i = 0; i < 3; i++) run_seq(2, 0, 16'h0, -1, -1, -1);
        n_checks++;
        if (n_done !== 3) begin
            n_fail++;
            $display("FAIL b2b_done got %0d exp 3", n_done);
        end
    endtask

    initial begin
        model_reset();
        clear_counts();
        test_reset();
        test_full_load();
        test_bubbles();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
